// File: rtl/dual_port_ram_be.sv
// -----------------------------------------------------------------------------
// dual_port_ram_be
//
// Simple dual-port RAM (one write port, one read port, shared clock) with
// per-byte write enables, a configurable read-during-write result, an
// optional extra output register, and a zero-fill sweep that runs after
// every reset and whenever 'clear' is requested.
//
// Parameters
//   DATA_WIDTH : word width in bits, multiple of 8
//   ADDR_WIDTH : address width, depth = 2**ADDR_WIDTH
//   RDW_MODE   : same-address read during write: 0 = old word, 1 = merged word
//   OUT_REG    : 1 = one extra output register stage (read latency 2)
//
// Ports
//   clock      : rising-edge clock
//   reset_n    : asynchronous active-low reset (starts a sweep)
//   clear      : request a zero-fill sweep of the whole memory
//   busy       : high while the sweep runs; user reads/writes are ignored
//   data       : write data
//   write_addr : write address
//   we         : write enable
//   be         : byte enables, be[i] covers data[8i+7:8i]
//   read_addr  : read address
//   re         : read enable
//   q          : read data, held between read results
//   q_valid    : one-cycle pulse when q carries a new read result
// -----------------------------------------------------------------------------
module dual_port_ram_be #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5,
   parameter int RDW_MODE   = 0,
   parameter int OUT_REG    = 0
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    clear,
   output logic                    busy,
   input  logic [DATA_WIDTH-1:0]   data,
   input  logic [ADDR_WIDTH-1:0]   write_addr,
   input  logic                    we,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [ADDR_WIDTH-1:0]   read_addr,
   input  logic                    re,
   output logic [DATA_WIDTH-1:0]   q,
   output logic                    q_valid
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {
      S_IDLE,
      S_CLEAR
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   clr_cnt;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    wr_ok;
   logic                    rd_ok;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic                    rd_valid;
   logic [DATA_WIDTH-1:0]   rd_data;

   // User accesses only count while no sweep is running.
   assign wr_ok = we & ~busy;
   assign rd_ok = re & ~busy;

   // Sweep controller. busy is kept as its own flop, always equal to
   // (state == S_CLEAR), so the output comes straight from a register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_CLEAR;
         busy    <= 1'b1;
         clr_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (clear) begin
                  state   <= S_CLEAR;
                  busy    <= 1'b1;
                  clr_cnt <= '0;
               end
            end
            S_CLEAR: begin
               // clear is ignored here: the sweep neither restarts nor extends.
               clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
               if (clr_cnt == {ADDR_WIDTH{1'b1}}) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_CLEAR;
               busy  <= 1'b1;
            end
         endcase
      end
   end

   // Storage write port: sweep writes take priority over (ignored) user writes.
   // NOTE: the array has no reset so it can map onto RAM macros; zeroing is
   // done by the sweep that reset itself triggers.
   always_ff @(posedge clock) begin
      if (busy) begin
         mem[clr_cnt] <= '0;
      end else if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
               mem[write_addr][8*i +: 8] <= data[8*i +: 8];
            end
         end
      end
   end

   // Read word, optionally with same-cycle write bytes forwarded.
   // NOTE: rd_word gets a full default before any conditional update so no
   // latch is inferred.
   always_comb begin
      rd_word = mem[read_addr];
      if (RDW_MODE != 0 && wr_ok && write_addr == read_addr) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
               rd_word[8*i +: 8] = data[8*i +: 8];
            end
         end
      end
   end

   // First read stage: data is only loaded on an accepted read so it holds
   // between results.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_ok;
         if (rd_ok) begin
            rd_data <= rd_word;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic                  out_valid;
         logic [DATA_WIDTH-1:0] out_data;

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               out_valid <= 1'b0;
               out_data  <= '0;
            end else begin
               out_valid <= rd_valid;
               if (rd_valid) begin
                  out_data <= rd_data;
               end
            end
         end

         assign q       = out_data;
         assign q_valid = out_valid;
      end else begin : g_no_out_reg
         assign q       = rd_data;
         assign q_valid = rd_valid;
      end
   endgenerate

endmodule

// File: tb/tb_dual_port_ram_be.sv
// -----------------------------------------------------------------------------
// tb_dual_port_ram_be
//
// Self-checking bench for dual_port_ram_be (DATA_WIDTH=16, ADDR_WIDTH=5).
// Reads push their expected word and due cycle onto a scoreboard queue; a
// monitor on the falling edge pops and compares whenever q_valid is seen,
// and checks that q holds its last value otherwise.
// -----------------------------------------------------------------------------
module tb_dual_port_ram_be;

   localparam int DW    = 16;
   localparam int AW    = 5;
   localparam int RDW   = 0;
   localparam int OREG  = 0;
   localparam int DEPTH = 32;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic            clear = 1'b0;
   logic            busy;
   logic [DW-1:0]   data = '0;
   logic [AW-1:0]   write_addr = '0;
   logic            we = 1'b0;
   logic [DW/8-1:0] be = '0;
   logic [AW-1:0]   read_addr = '0;
   logic            re = 1'b0;
   logic [DW-1:0]   q;
   logic            q_valid;

   dual_port_ram_be #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RDW_MODE   (RDW),
      .OUT_REG    (OREG)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear      (clear),
      .busy       (busy),
      .data       (data),
      .write_addr (write_addr),
      .we         (we),
      .be         (be),
      .read_addr  (read_addr),
      .re         (re),
      .q          (q),
      .q_valid    (q_valid)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc++;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t          sb[$];
   exp_t          e;
   logic [DW-1:0] last_q = '0;
   logic [DW-1:0] model_mem [DEPTH];

   typedef struct {
      logic            w;
      logic [AW-1:0]   wa;
      logic [DW-1:0]   wd;
      logic [DW/8-1:0] b;
      logic            r;
      logic [AW-1:0]   ra;
      logic [DW-1:0]   exp_q;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Read-result monitor, away from the active edge.
   always @(negedge clock) begin
      if (!reset_n) begin
         last_q = '0;
      end else if (q_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_q_valid", 32'(q_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            check("read_cycle", cyc, e.due);
            check("read_data", 32'(q), 32'(e.data));
            last_q = e.data;
         end
      end else begin
         check("q_hold", 32'(q), 32'(last_q));
      end
   end

   // Drive one cycle of stimulus from a falling edge; a read that the design
   // should accept is queued with its expected word and due cycle.
   task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [DW/8-1:0] b, input logic r, input logic [AW-1:0] ra,
                        input logic accepted, input logic [DW-1:0] exp_q);
      we         = w;
      write_addr = wa;
      data       = wd;
      be         = b;
      re         = r;
      read_addr  = ra;
      if (r && accepted) sb.push_back(exp_t'{exp_q, cyc + 1 + OREG});
      @(negedge clock);
      we = 1'b0;
      re = 1'b0;
   endtask

   // Count rising edges until busy drops; a sweep must take DEPTH edges.
   task automatic wait_sweep(input string name);
      int n = 0;
      do begin
         @(posedge clock);
         n++;
         #1;
      end while (busy && n < 100);
      check(name, n, DEPTH);
      @(negedge clock);
   endtask

   task automatic read_all_zero();
      for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, '0, '0, 1'b1, AW'(i), 1'b1, 16'h0000);
      repeat (3) @(negedge clock);
   endtask

   task automatic fill_model(input logic [DW-1:0] seed);
      for (int i = 0; i < DEPTH; i++) begin
         model_mem[i] = seed ^ DW'(i * 16'h0101);
         drive(1'b1, AW'(i), model_mem[i], 2'b11, 1'b0, '0, 1'b0, '0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish before %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      // Table: byte enables, read-during-write, latency, be=0, throughput.
      vecs[0]  = '{1'b1, 5'd3,  16'hA5A5, 2'b11, 1'b0, 5'd0,  16'h0000};
      vecs[1]  = '{1'b1, 5'd3,  16'h00FF, 2'b01, 1'b0, 5'd0,  16'h0000};
      vecs[2]  = '{1'b0, 5'd0,  16'h0000, 2'b00, 1'b1, 5'd3,  16'hA5FF};
      vecs[3]  = '{1'b1, 5'd7,  16'h1234, 2'b11, 1'b0, 5'd0,  16'h0000};
      vecs[4]  = '{1'b1, 5'd7,  16'hBEEF, 2'b10, 1'b1, 5'd7,  (RDW != 0) ? 16'hBE34 : 16'h1234};
      vecs[5]  = '{1'b0, 5'd0,  16'h0000, 2'b00, 1'b1, 5'd7,  16'hBE34};
      vecs[6]  = '{1'b1, 5'd2,  16'h0042, 2'b11, 1'b0, 5'd0,  16'h0000};
      vecs[7]  = '{1'b0, 5'd0,  16'h0000, 2'b00, 1'b1, 5'd2,  16'h0042};
      vecs[8]  = '{1'b1, 5'd2,  16'hFFFF, 2'b00, 1'b0, 5'd0,  16'h0000};
      vecs[9]  = '{1'b0, 5'd0,  16'h0000, 2'b00, 1'b1, 5'd2,  16'h0042};
      vecs[10] = '{1'b1, 5'd31, 16'hFFFF, 2'b11, 1'b1, 5'd0,  16'h0000};
      vecs[11] = '{1'b0, 5'd0,  16'h0000, 2'b00, 1'b1, 5'd31, 16'hFFFF};
      vecs[12] = '{1'b1, 5'd0,  16'h1111, 2'b01, 1'b1, 5'd0,  (RDW != 0) ? 16'h0011 : 16'h0000};
      vecs[13] = '{1'b0, 5'd0,  16'h0000, 2'b00, 1'b0, 5'd0,  16'h0000};
      vecs[14] = '{1'b0, 5'd0,  16'h0000, 2'b00, 1'b1, 5'd0,  16'h0011};

      // Reset state.
      repeat (3) @(negedge clock);
      check("reset_busy", 32'(busy), 32'd1);
      check("reset_q", 32'(q), 32'd0);
      check("reset_q_valid", 32'(q_valid), 32'd0);

      // Post-reset sweep, then whole memory reads zero.
      reset_n = 1'b1;
      wait_sweep("post_reset_busy_cycles");
      read_all_zero();

      // Table-driven vectors.
      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].w, vecs[i].wa, vecs[i].wd, vecs[i].b, vecs[i].r, vecs[i].ra, 1'b1, vecs[i].exp_q);
      end
      repeat (3) @(negedge clock);

      // Full-throughput fill: write addr i while reading back addr i-1.
      for (int i = 0; i <= DEPTH; i++) begin
         if (i < DEPTH) model_mem[i] = 16'h3C00 ^ DW'(i * 16'h0107);
         drive(i < DEPTH, AW'(i), (i < DEPTH) ? model_mem[i] : 16'h0000, 2'b11,
               i > 0, AW'(i - 1), 1'b1, (i > 0) ? model_mem[i - 1] : 16'h0000);
      end
      repeat (3) @(negedge clock);

      // Clear with accesses (and a second clear) ignored during the sweep.
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         check("busy_during_clear", 32'(busy), 32'd1);
         clear = (k == 5);
         drive(1'b1, AW'($urandom_range(31, 0)), DW'($urandom), 2'b11,
               1'b1, AW'($urandom_range(31, 0)), 1'b0, '0);
      end
      clear = 1'b0;
      check("busy_after_clear", 32'(busy), 32'd0);
      read_all_zero();

      // Reset asserted when the sweep counter reaches 10.
      fill_model(16'hC3A1);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      for (int k = 0; k < 10; k++) drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      check("busy_in_mid_sweep_reset", 32'(busy), 32'd1);
      check("q_valid_in_mid_sweep_reset", 32'(q_valid), 32'd0);
      reset_n = 1'b1;
      wait_sweep("restart_busy_cycles");
      read_all_zero();

      check("scoreboard_empty", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
